uart_cmd_ctrl: RTL and testbench

//  Command sequencer behind the UART receiver. Consumes received bytes (rx_valid pulses) and decodes

---
 rtl/uart_cmd_ctrl_pkg.sv | 33 +++
 rtl/uart_cmd_ctrl_if.sv | 37 +++
 rtl/uart_cmd_timeout.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM state encoding
// and the register-file addresses that hold the ALU operands.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] CMD_WR     = 8'hAA;
   localparam logic [7:0] CMD_RD     = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP = 8'hCC;
   localparam logic [7:0] CMD_ALU    = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_ADDR  = 4'd1,
      ST_WR_DATA  = 4'd2,
      ST_RD_ADDR  = 4'd3,
      ST_RD_WAIT  = 4'd4,
      ST_OPA      = 4'd5,
      ST_OPB      = 4'd6,
      ST_ALU_FUN  = 4'd7,
      ST_ALU_WAIT = 4'd8,
      ST_TX_LO    = 4'd9,
      ST_TX_HI    = 4'd10
   } state_t;

   // States in which the sequencer is still collecting bytes of a frame.
   function automatic logic in_frame_state(input state_t s);
      return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
             (s == ST_OPA) || (s == ST_OPB) || (s == ST_ALU_FUN);
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the command sequencer (master) and its environment:
// UART RX/TX, register file and ALU (slave).
interface uart_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   // Handshakes: rx_valid, rf_rd_valid, alu_valid, tx_valid and the rf/alu strobes are
   // single-cycle pulses; a tx_valid pulse is only ever issued in a cycle where tx_busy is low.
   logic [DATA_WIDTH-1:0]   rx_data;
   logic                    rx_valid;
   logic                    rx_err;
   logic                    rf_wr_en;
   logic                    rf_rd_en;
   logic [ADDR_WIDTH-1:0]   rf_addr;
   logic [DATA_WIDTH-1:0]   rf_wr_data;
   logic [DATA_WIDTH-1:0]   rf_rd_data;
   logic                    rf_rd_valid;
   logic                    alu_en;
   logic [3:0]              alu_fun;
   logic [2*DATA_WIDTH-1:0] alu_out;
   logic                    alu_valid;
   logic                    alu_clk_en;
   logic [DATA_WIDTH-1:0]   tx_data;
   logic                    tx_valid;
   logic                    tx_busy;

   modport master (
      input  rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_busy,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, alu_clk_en, tx_data, tx_valid
   );

   modport slave (
      output rx_data, rx_valid, rx_err, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_busy,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, alu_clk_en, tx_data, tx_valid
   );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter that flags an idle partial frame; only built when
// FRAME_TIMEOUT_EN is defined.
`ifdef FRAME_TIMEOUT_EN
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic load,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= CW'(TIMEOUT_CYC);
      end else if (load || !en) begin
         count <= CW'(TIMEOUT_CYC);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
   assign expired = en && !load && (count == CW'(1));

endmodule
`endif

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between UART RX and the register file / ALU / UART TX.
// Optional feature: FRAME_TIMEOUT_EN drops partial frames after TIMEOUT_CYC idle cycles.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int          DATA_WIDTH  = 8,
   parameter int          ADDR_WIDTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic             clk,
   input  logic             rst,
   uart_cmd_ctrl_if.master  bus,
   output state_t           dbg_state
);

   if (TIMEOUT_CYC < 2 || ADDR_WIDTH > DATA_WIDTH || DATA_WIDTH < 4) begin : g_param_chk
      $error("uart_cmd_ctrl: unsupported parameter combination");
   end

   state_t                  state, state_nxt;
   logic                    wr_en_q, wr_en_nxt;
   logic                    rd_en_q, rd_en_nxt;
   logic                    alu_en_q, alu_en_nxt;
   logic                    clk_en_q, clk_en_nxt;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
   logic [3:0]              fun_q, fun_nxt;
   logic [2*DATA_WIDTH-1:0] result_q, result_nxt;
   logic                    two_byte_q, two_byte_nxt;
   logic                    tx_valid;
   logic                    byte_ok;
   logic                    in_frame;
   logic                    frame_err;
   logic                    timeout_hit;

   assign in_frame  = in_frame_state(state);
   assign byte_ok   = bus.rx_valid && !bus.rx_err;
   assign frame_err = bus.rx_valid && bus.rx_err && in_frame;

`ifdef FRAME_TIMEOUT_EN
   uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .en      (in_frame),
      .load    (bus.rx_valid),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         alu_en_q   <= 1'b0;
         clk_en_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         fun_q      <= '0;
         result_q   <= '0;
         two_byte_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_en_q    <= wr_en_nxt;
         rd_en_q    <= rd_en_nxt;
         alu_en_q   <= alu_en_nxt;
         clk_en_q   <= clk_en_nxt;
         addr_q     <= addr_nxt;
         wdata_q    <= wdata_nxt;
         fun_q      <= fun_nxt;
         result_q   <= result_nxt;
         two_byte_q <= two_byte_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wr_en_nxt    = 1'b0;
      rd_en_nxt    = 1'b0;
      alu_en_nxt   = 1'b0;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      fun_nxt      = fun_q;
      result_nxt   = result_q;
      two_byte_nxt = two_byte_q;
      tx_valid     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (byte_ok) begin
               case (bus.rx_data)
                  DATA_WIDTH'(CMD_WR):     state_nxt = ST_WR_ADDR;
                  DATA_WIDTH'(CMD_RD):     state_nxt = ST_RD_ADDR;
                  DATA_WIDTH'(CMD_ALU_OP): state_nxt = ST_OPA;
                  DATA_WIDTH'(CMD_ALU):    state_nxt = ST_ALU_FUN;
                  default:                 state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_WR_ADDR: begin
            if (byte_ok) begin
               addr_nxt  = bus.rx_data[ADDR_WIDTH-1:0];
               state_nxt = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (byte_ok) begin
               wdata_nxt = bus.rx_data;
               wr_en_nxt = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (byte_ok) begin
               addr_nxt  = bus.rx_data[ADDR_WIDTH-1:0];
               rd_en_nxt = 1'b1;
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (bus.rf_rd_valid) begin
               result_nxt   = {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
               two_byte_nxt = 1'b0;
               state_nxt    = ST_TX_LO;
            end
         end
         ST_OPA: begin
            if (byte_ok) begin
               addr_nxt  = ADDR_WIDTH'(OPA_ADDR);
               wdata_nxt = bus.rx_data;
               wr_en_nxt = 1'b1;
               state_nxt = ST_OPB;
            end
         end
         ST_OPB: begin
            if (byte_ok) begin
               addr_nxt  = ADDR_WIDTH'(OPB_ADDR);
               wdata_nxt = bus.rx_data;
               wr_en_nxt = 1'b1;
               state_nxt = ST_ALU_FUN;
            end
         end
         ST_ALU_FUN: begin
            if (byte_ok) begin
               fun_nxt    = bus.rx_data[3:0];
               alu_en_nxt = 1'b1;
               state_nxt  = ST_ALU_WAIT;
            end
         end
         ST_ALU_WAIT: begin
            if (bus.alu_valid) begin
               result_nxt   = bus.alu_out;
               two_byte_nxt = 1'b1;
               state_nxt    = ST_TX_LO;
            end
         end
         ST_TX_LO: begin
            if (!bus.tx_busy) begin
               tx_valid  = 1'b1;
               state_nxt = two_byte_q ? ST_TX_HI : ST_IDLE;
            end
         end
         ST_TX_HI: begin
            if (!bus.tx_busy) begin
               tx_valid  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A corrupted byte or a stalled frame abandons the frame without any strobe.
      if (frame_err || timeout_hit) begin
         state_nxt  = ST_IDLE;
         wr_en_nxt  = 1'b0;
         rd_en_nxt  = 1'b0;
         alu_en_nxt = 1'b0;
      end

      clk_en_nxt = (state_nxt == ST_ALU_FUN) || (state_nxt == ST_ALU_WAIT) ||
                   (((state_nxt == ST_TX_LO) || (state_nxt == ST_TX_HI)) && two_byte_nxt);
   end

   assign bus.rf_wr_en   = wr_en_q;
   assign bus.rf_rd_en   = rd_en_q;
   assign bus.rf_addr    = addr_q;
   assign bus.rf_wr_data = wdata_q;
   assign bus.alu_en     = alu_en_q;
   assign bus.alu_fun    = fun_q;
   assign bus.alu_clk_en = clk_en_q;
   assign bus.tx_valid   = tx_valid;
   assign bus.tx_data    = (state == ST_TX_HI) ? result_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                           (state == ST_TX_LO) ? result_q[DATA_WIDTH-1:0] : '0;
   assign dbg_state      = state;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with register-file/ALU responders and a TX byte scoreboard.
module tb_uart_cmd_ctrl;
   import uart_cmd_ctrl_pkg::*;

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned TO_CYC = 16;
`else
   localparam int unsigned TO_CYC = 4096;
`endif

   logic   clk;
   logic   rst;
   state_t dbg_state;

   uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   int          wr_cnt   = 0;
   int          rd_cnt   = 0;
   int          alu_cnt  = 0;
   int          tx_cnt   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rd_value;
   logic [15:0] alu_value;
   int          alu_delay;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input logic err);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      bus.rx_err   = err;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_err   = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic wait_tx(input int target);
      int budget = 200;
      while (tx_cnt < target && budget > 0) begin
         @(negedge clk);
         #2;
         budget--;
      end
      check("tx_wait", 32'(tx_cnt), 32'(target));
   endtask

   // register-file read responder
   initial begin
      bus.rf_rd_valid = 1'b0;
      bus.rf_rd_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst && bus.rf_rd_en) begin
            @(negedge clk);
            bus.rf_rd_data  = rd_value;
            bus.rf_rd_valid = 1'b1;
            @(negedge clk);
            bus.rf_rd_valid = 1'b0;
         end
      end
   end

   // ALU responder
   initial begin
      bus.alu_valid = 1'b0;
      bus.alu_out   = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst && bus.alu_en) begin
            repeat (alu_delay) @(negedge clk);
            bus.alu_out   = alu_value;
            bus.alu_valid = 1'b1;
            @(negedge clk);
            bus.alu_valid = 1'b0;
         end
      end
   end

   // monitor and TX scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            if (bus.rf_wr_en) wr_cnt++;
            if (bus.rf_rd_en) rd_cnt++;
            if (bus.alu_en)   alu_cnt++;
            if (bus.tx_valid) begin
               tx_cnt++;
               check("tx_while_busy", 32'(bus.tx_busy), 32'd0);
               if (exp_q.size() == 0) begin
                  check("tx_extra_byte", 32'(exp_q.size()), 32'd1);
               end else begin
                  check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      int wr0, rd0, alu0, tx0;
      rst          = 1'b0;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.rx_err   = 1'b0;
      bus.tx_busy  = 1'b0;
      rd_value     = '0;
      alu_value    = '0;
      alu_delay    = 2;

      // reset state
      tick(3);
      check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
      check("rst_wr_en",    32'(bus.rf_wr_en), 32'd0);
      check("rst_rd_en",    32'(bus.rf_rd_en), 32'd0);
      check("rst_alu_en",   32'(bus.alu_en), 32'd0);
      check("rst_clk_en",   32'(bus.alu_clk_en), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_addr",     32'(bus.rf_addr), 32'd0);
      check("rst_tx_data",  32'(bus.tx_data), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // write AA,05,3C
      wr0 = wr_cnt; tx0 = tx_cnt;
      send_byte(8'hAA, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h3C, 1'b0);
      #2;
      check("wr_latency", 32'(bus.rf_wr_en), 32'd1);
      check("wr_addr",    32'(bus.rf_addr), 32'h5);
      check("wr_data",    32'(bus.rf_wr_data), 32'h3C);
      tick(4);
      check("wr_pulses",  32'(wr_cnt - wr0), 32'd1);
      check("wr_no_tx",   32'(tx_cnt - tx0), 32'd0);

      // read BB,07 returning 5A
      rd0 = rd_cnt; tx0 = tx_cnt;
      rd_value = 8'h5A;
      exp_q.push_back(8'h5A);
      send_byte(8'hBB, 1'b0);
      send_byte(8'h07, 1'b0);
      #2;
      check("rd_latency", 32'(bus.rf_rd_en), 32'd1);
      check("rd_addr",    32'(bus.rf_addr), 32'h7);
      wait_tx(tx0 + 1);
      tick(3);
      check("rd_pulses",  32'(rd_cnt - rd0), 32'd1);
      check("rd_tx_once", 32'(tx_cnt - tx0), 32'd1);
      check("rd_idle",    32'(dbg_state), 32'(ST_IDLE));

      // ALU with operands CC,03,04,00 -> 0x0007
      wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
      alu_value = 16'h0007;
      exp_q.push_back(8'h07);
      exp_q.push_back(8'h00);
      send_byte(8'hCC, 1'b0);
      send_byte(8'h03, 1'b0);
      #2;
      check("opa_wr_en",  32'(bus.rf_wr_en), 32'd1);
      check("opa_addr",   32'(bus.rf_addr), 32'h0);
      check("opa_data",   32'(bus.rf_wr_data), 32'h03);
      send_byte(8'h04, 1'b0);
      #2;
      check("opb_wr_en",  32'(bus.rf_wr_en), 32'd1);
      check("opb_addr",   32'(bus.rf_addr), 32'h1);
      check("opb_data",   32'(bus.rf_wr_data), 32'h04);
      check("fun_clk_en", 32'(bus.alu_clk_en), 32'd1);
      send_byte(8'h00, 1'b0);
      #2;
      check("alu_latency", 32'(bus.alu_en), 32'd1);
      check("alu_fun0",    32'(bus.alu_fun), 32'h0);
      wait_tx(tx0 + 2);
      tick(1);
      check("alu_clk_off", 32'(bus.alu_clk_en), 32'd0);
      check("alu_pulses",  32'(alu_cnt - alu0), 32'd1);
      check("op_wr_count", 32'(wr_cnt - wr0), 32'd2);

      // ALU DD,02 with transmitter busy for 20 cycles
      tx0 = tx_cnt;
      alu_value = 16'h1234;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      bus.tx_busy = 1'b1;
      send_byte(8'hDD, 1'b0);
      #2;
      check("dd_clk_en", 32'(bus.alu_clk_en), 32'd1);
      send_byte(8'h02, 1'b0);
      #2;
      check("dd_fun", 32'(bus.alu_fun), 32'h2);
      tick(20);
      check("busy_no_tx",  32'(tx_cnt - tx0), 32'd0);
      check("busy_state",  32'(dbg_state), 32'(ST_TX_LO));
      check("busy_clk_en", 32'(bus.alu_clk_en), 32'd1);
      @(negedge clk);
      bus.tx_busy = 1'b0;
      wait_tx(tx0 + 2);
      tick(1);
      check("dd_clk_off", 32'(bus.alu_clk_en), 32'd0);

      // rx_err aborts a write frame, then a clean write
      wr0 = wr_cnt;
      send_byte(8'hAA, 1'b0);
      send_byte(8'h05, 1'b1);
      #2;
      check("err_idle", 32'(dbg_state), 32'(ST_IDLE));
      send_byte(8'h3C, 1'b0);
      tick(3);
      check("err_no_wr", 32'(wr_cnt - wr0), 32'd0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h11, 1'b0);
      #2;
      check("post_err_wr_en", 32'(bus.rf_wr_en), 32'd1);
      check("post_err_addr",  32'(bus.rf_addr), 32'h1);
      check("post_err_data",  32'(bus.rf_wr_data), 32'h11);

      // unknown opcode ignored; upper address bits dropped
      send_byte(8'h12, 1'b0);
      #2;
      check("unknown_idle", 32'(dbg_state), 32'(ST_IDLE));
      send_byte(8'hAA, 1'b0);
      send_byte(8'hF3, 1'b0);
      send_byte(8'h99, 1'b0);
      #2;
      check("addr_trunc", 32'(bus.rf_addr), 32'h3);
      check("trunc_data", 32'(bus.rf_wr_data), 32'h99);

      // byte during ALU_WAIT is dropped
      wr0 = wr_cnt; tx0 = tx_cnt;
      alu_delay = 4;
      alu_value = 16'hBEEF;
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      send_byte(8'hDD, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'hAA, 1'b0);
      #2;
      check("drop_wait_state", 32'(dbg_state), 32'(ST_ALU_WAIT));
      wait_tx(tx0 + 2);
      tick(2);
      check("drop_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("drop_no_wr", 32'(wr_cnt - wr0), 32'd0);
      alu_delay = 2;

      // asynchronous reset mid-frame
      wr0 = wr_cnt;
      send_byte(8'hAA, 1'b0);
      send_byte(8'h05, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("async_rst_addr",  32'(bus.rf_addr), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      send_byte(8'h3C, 1'b0);
      tick(3);
      check("async_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);

`ifdef FRAME_TIMEOUT_EN
      // partial frame dropped after TIMEOUT_CYC idle cycles
      wr0 = wr_cnt;
      send_byte(8'hAA, 1'b0);
      tick(15);
      check("to_still_wait", 32'(dbg_state), 32'(ST_WR_ADDR));
      tick(1);
      check("to_idle", 32'(dbg_state), 32'(ST_IDLE));
      send_byte(8'h05, 1'b0);
      #2;
      check("to_byte_ignored", 32'(dbg_state), 32'(ST_IDLE));
      send_byte(8'h3C, 1'b0);
      tick(3);
      check("to_no_wr", 32'(wr_cnt - wr0), 32'd0);
`endif

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
